seq_signed_multiplier: RTL and testbench

SEQ_SIGNED_MULTIPLIER -- requirements
Module: seq_signed_multiplier

---
 rtl/seq_signed_multiplier.sv | 110 +++++++++++
 tb/tb_seq_signed_multiplier.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seq_signed_multiplier.sv
// Sequential 8x8 signed shift-add multiplier, one partial product per cycle.
// Define SEQ_MUL_EARLY_EXIT_EN to stop as soon as the multiplier runs out of ones.
module seq_signed_multiplier (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic        busy,
   output logic        done,
   output logic [15:0] result
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] mcand;
   logic [15:0] acc;
   logic [15:0] acc_nxt;
   logic [15:0] addend;
   logic [7:0]  mplier;
   logic [7:0]  mplier_nxt;
   logic [7:0]  a_mag;
   logic [7:0]  b_mag;
   logic [3:0]  count;
   logic        sign;
   logic        last_step;

   // -128 negates to 8'h80, which reads correctly as unsigned 128
   assign a_mag = a[7] ? (~a + 8'd1) : a;
   assign b_mag = b[7] ? (~b + 8'd1) : b;

   always_comb begin
      addend     = mcand << count;
      acc_nxt    = mplier[0] ? (acc + addend) : acc;
      mplier_nxt = mplier >> 1;
`ifdef SEQ_MUL_EARLY_EXIT_EN
      last_step  = (mplier_nxt == 8'd0) || (count == 4'd7);
`else
      last_step  = (count == 4'd7);
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = CALC;
         CALC:    if (last_step) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      unique case (state)
         CALC:    busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mcand  <= 16'd0;
         mplier <= 8'd0;
         sign   <= 1'b0;
         acc    <= 16'd0;
         count  <= 4'd0;
         result <= 16'd0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  mcand  <= {8'd0, a_mag};
                  mplier <= b_mag;
                  sign   <= a[7] ^ b[7];
                  acc    <= 16'd0;
                  count  <= 4'd0;
               end
            end
            CALC: begin
               acc    <= acc_nxt;
               mplier <= mplier_nxt;
               count  <= count + 4'd1;
               // negating a zero magnitude yields zero, so no negative zero
               if (last_step) begin
                  result <= sign ? (~acc_nxt + 16'd1) : acc_nxt;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_signed_multiplier.sv
// Directed vector bench for seq_signed_multiplier (both build variants).
// Expected latency follows the SEQ_MUL_EARLY_EXIT_EN setting of the compile.
module tb_seq_signed_multiplier;

   logic        clk;
   logic        reset;
   logic        start;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        busy;
   logic        done;
   logic [15:0] result;

   int pass_cnt;
   int total_cnt;

   typedef struct {
      logic [7:0]  va;
      logic [7:0]  vb;
      logic [15:0] prod;
      string       name;
   } vec_t;

   vec_t vecs[13];

   seq_signed_multiplier dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int exp_lat(input logic [7:0] bv);
`ifdef SEQ_MUL_EARLY_EXIT_EN
      logic [7:0] mag;
      int         hi;
      mag = bv[7] ? (~bv + 8'd1) : bv;
      hi  = 0;
      for (int i = 0; i < 8; i++) begin
         if (mag[i]) hi = i;
      end
      return hi + 2;
`else
      return 9;
`endif
   endfunction

   // start driven in cycle 0; returns at the negedge of the done cycle
   task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v,
                         input logic [15:0] prod, input int repulse,
                         input string name);
      int lat;
      int done_cyc;
      int busy_n;
      int busy_in_done;
      lat          = exp_lat(tb_v);
      done_cyc     = -1;
      busy_n       = 0;
      busy_in_done = 0;
      @(posedge clk);
      #1;
      a     = ta;
      b     = tb_v;
      start = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         a     = 8'($urandom);
         b     = 8'($urandom);
         if (n == repulse) begin
            start = 1'b1;
            a     = 8'd1;
            b     = 8'd1;
         end
         @(negedge clk);
         if (busy) busy_n++;
         if (done) begin
            done_cyc     = n;
            busy_in_done = int'(busy);
            break;
         end
      end
      check({name, " done_cycle"}, done_cyc, lat);
      check({name, " result"}, int'(result), int'(prod));
      check({name, " busy_cycles"}, busy_n, lat - 1);
      check({name, " busy_in_done"}, busy_in_done, 0);
   endtask

   initial begin
      int dones;
      pass_cnt  = 0;
      total_cnt = 0;
      reset     = 1'b1;
      start     = 1'b0;
      a         = 8'd0;
      b         = 8'd0;

      vecs[0]  = '{8'd3,    8'd5,    16'h000F, "3x5"};
      vecs[1]  = '{8'hF9,   8'd6,    16'hFFD6, "m7x6"};
      vecs[2]  = '{8'h80,   8'h80,   16'h4000, "m128xm128"};
      vecs[3]  = '{8'h80,   8'h7F,   16'hC080, "m128x127"};
      vecs[4]  = '{8'd0,    8'hFB,   16'h0000, "0xm5"};
      vecs[5]  = '{8'd9,    8'd1,    16'h0009, "9x1"};
      vecs[6]  = '{8'd9,    8'h80,   16'hFB80, "9xm128"};
      vecs[7]  = '{8'h7F,   8'h7F,   16'h3F01, "127x127"};
      vecs[8]  = '{8'hFF,   8'hFF,   16'h0001, "m1xm1"};
      vecs[9]  = '{8'd1,    8'hFF,   16'hFFFF, "1xm1"};
      vecs[10] = '{8'd5,    8'd0,    16'h0000, "5x0"};
      vecs[11] = '{8'hFD,   8'd7,    16'hFFEB, "m3x7"};
      vecs[12] = '{8'd100,  8'h9C,   16'hD8F0, "100xm100"};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset busy", int'(busy), 0);
      check("reset done", int'(done), 0);
      check("reset result", int'(result), 0);

      // start together with reset must not launch an operation
      @(posedge clk);
      #1;
      start = 1'b1;
      a     = 8'd3;
      b     = 8'd5;
      @(posedge clk);
      #1;
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check("start_with_reset busy", int'(busy), 0);

      foreach (vecs[i]) begin
         run_op(vecs[i].va, vecs[i].vb, vecs[i].prod, 0, vecs[i].name);
      end

      repeat (3) @(negedge clk);
      check("result_hold", int'(result), 16'hD8F0);

      // re-pulse in cycle 4 ignored, then back-to-back start accepted
      run_op(8'd3, 8'd5, 16'h000F, 4, "repulse");
      run_op(8'hF9, 8'd6, 16'hFFD6, 0, "back_to_back");

      // reset in cycle 5 of a long operation discards it
      @(posedge clk);
      #1;
      a     = 8'd9;
      b     = 8'h80;
      start = 1'b1;
      for (int n = 1; n <= 5; n++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         if (n == 5) reset = 1'b1;
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("midreset busy", int'(busy), 0);
      check("midreset done", int'(done), 0);
      check("midreset result", int'(result), 0);
      dones = 0;
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         if (done || busy) dones++;
      end
      check("midreset no_activity", dones, 0);

      run_op(8'd3, 8'd5, 16'h000F, 0, "after_reset");

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
